// File: rtl/pic_pkg.sv
// Shared definitions for the PIC16-style core: phase encoding, instruction
// width and the opcode field constants used by the sequencer decode.
package pic_pkg;

  typedef enum logic [2:0] {
    ST_HALT,
    ST_Q1,
    ST_Q2,
    ST_Q3,
    ST_Q4
  } phase_t;

  localparam int OPCODE_W = 14;

  localparam logic [13:0] NOP    = 14'h0000;
  localparam logic [13:0] RETURN = 14'h0008;

  // Instruction class, inst_reg[13:12]
  localparam logic [1:0] CLS_BYTE   = 2'b00;
  localparam logic [1:0] CLS_BIT    = 2'b01;
  localparam logic [1:0] CLS_BRANCH = 2'b10;
  localparam logic [1:0] CLS_LIT    = 2'b11;

  // Sub-opcodes on inst_reg[13:10]
  localparam logic [3:0] OP_BCF   = 4'b0100;
  localparam logic [3:0] OP_BSF   = 4'b0101;
  localparam logic [3:0] OP_BTFSC = 4'b0110;
  localparam logic [3:0] OP_BTFSS = 4'b0111;
  localparam logic [3:0] OP_RETLW = 4'b1101;

  // Byte-op sub-opcodes on inst_reg[11:8]
  localparam logic [3:0] OP_DECFSZ = 4'b1011;
  localparam logic [3:0] OP_INCFSZ = 4'b1111;

endpackage

// File: rtl/pic_stack.sv
// 8-entry return-address stack with a wrapping 3-bit pointer and a sticky
// overflow/underflow flag. Read data is the entry a pop would return.
module pic_stack #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] pop_data,
  output logic            stack_err
);

  logic [PC_W-1:0] mem [8];
  logic [2:0]      sp;
  logic [3:0]      depth;

  assign pop_data = mem[sp - 3'd1];

  // depth tracks true nesting only to flag errors; the pointer always wraps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp        <= '0;
      depth     <= '0;
      stack_err <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) mem[i] <= '0;
    end else if (push) begin
      mem[sp] <= push_data;
      sp      <= sp + 3'd1;
      if (depth == 4'd8) stack_err <= 1'b1;
      else               depth     <= depth + 4'd1;
    end else if (pop) begin
      sp <= sp - 3'd1;
      if (depth == 4'd0) stack_err <= 1'b1;
      else               depth     <= depth - 4'd1;
    end
  end

endmodule

// File: rtl/pic_sequencer.sv
// Instruction-cycle sequencer: Q1..Q4 phase generation, PC/IR ownership,
// datapath strobes and branch/skip flush. Return stack under PIC_SEQ_STACK_EN.
module pic_sequencer
  import pic_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int OPCODE_W = pic_pkg::OPCODE_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                skip,
  output logic                clk1,
  output logic                clk2,
  output logic                clk3,
  output logic                clk4,
  output logic [PC_W-1:0]     pc,
  output logic [OPCODE_W-1:0] inst_reg,
  output logic                flush,
  output logic                ram_rd,
  output logic                ram_wr,
  output logic                w_wr,
  output logic                stack_err
);

  phase_t state;

  logic [1:0] cls;
  logic [3:0] fsel;
  logic [3:0] hi4;
  logic       dbit;
  logic       is_goto;
  logic       is_call;
  logic       is_skip_op;

  always_comb begin
    cls        = inst_reg[13:12];
    fsel       = inst_reg[11:8];
    hi4        = inst_reg[13:10];
    dbit       = inst_reg[7];
    is_goto    = (cls == CLS_BRANCH) &&  inst_reg[11];
    is_call    = (cls == CLS_BRANCH) && !inst_reg[11];
    is_skip_op = (hi4 == OP_BTFSC) || (hi4 == OP_BTFSS) ||
                 ((cls == CLS_BYTE) && ((fsel == OP_DECFSZ) || (fsel == OP_INCFSZ)));
  end

  assign ram_rd = clk2 & ~flush &
                  (((cls == CLS_BYTE) && (fsel != 4'd0)) || (cls == CLS_BIT));
  assign ram_wr = clk4 & ~flush &
                  (((cls == CLS_BYTE) && dbit) || (hi4 == OP_BCF) || (hi4 == OP_BSF));
  assign w_wr   = clk4 & ~flush &
                  (((cls == CLS_BYTE) && (fsel != 4'd0) && !dbit) || (cls == CLS_LIT));

`ifdef PIC_SEQ_STACK_EN
  logic            is_ret;
  logic            push;
  logic            pop;
  logic [PC_W-1:0] ret_addr;

  assign is_ret = (inst_reg == OPCODE_W'(RETURN)) || (hi4 == OP_RETLW);
  assign push   = clk4 & ~flush & is_call;
  assign pop    = clk4 & ~flush & is_ret;

  pic_stack #(.PC_W(PC_W)) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc),
    .pop_data  (ret_addr),
    .stack_err (stack_err)
  );
`else
  assign stack_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_HALT;
      clk1     <= 1'b0;
      clk2     <= 1'b0;
      clk3     <= 1'b0;
      clk4     <= 1'b0;
      pc       <= '0;
      inst_reg <= OPCODE_W'(NOP);
      flush    <= 1'b1;
    end else begin
      case (state)
        ST_HALT: begin
          if (run) begin
            state <= ST_Q1;
            clk1  <= 1'b1;
          end
        end
        ST_Q1: begin
          state <= ST_Q2;
          clk1  <= 1'b0;
          clk2  <= 1'b1;
        end
        ST_Q2: begin
          state <= ST_Q3;
          clk2  <= 1'b0;
          clk3  <= 1'b1;
        end
        ST_Q3: begin
          state <= ST_Q4;
          clk3  <= 1'b0;
          clk4  <= 1'b1;
        end
        ST_Q4: begin
          clk4 <= 1'b0;
          if (run) begin
            state <= ST_Q1;
            clk1  <= 1'b1;
          end else begin
            state <= ST_HALT;
          end
          // Without the stack, CALL collapses into the GOTO path and returns fall through
          if (!flush && (is_goto || is_call)) begin
            pc       <= inst_reg[PC_W-1:0];
            inst_reg <= OPCODE_W'(NOP);
            flush    <= 1'b1;
          end
`ifdef PIC_SEQ_STACK_EN
          else if (!flush && is_ret) begin
            pc       <= ret_addr;
            inst_reg <= OPCODE_W'(NOP);
            flush    <= 1'b1;
          end
`endif
          else if (!flush && is_skip_op && skip) begin
            pc       <= pc + PC_W'(1);
            inst_reg <= OPCODE_W'(NOP);
            flush    <= 1'b1;
          end else begin
            pc       <= pc + PC_W'(1);
            inst_reg <= opcode;
            flush    <= 1'b0;
          end
        end
        default: begin
          state <= ST_HALT;
          clk1  <= 1'b0;
          clk2  <= 1'b0;
          clk3  <= 1'b0;
          clk4  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pic_sequencer.sv
// Directed self-checking bench for pic_sequencer; covers the return-stack
// path when PIC_SEQ_STACK_EN is defined, the plain path otherwise.
module tb_pic_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [13:0] opcode;
  logic        skip;
  logic        clk1, clk2, clk3, clk4;
  logic [7:0]  pc;
  logic [13:0] inst_reg;
  logic        flush;
  logic        ram_rd, ram_wr, w_wr;
  logic        stack_err;

  logic [13:0] mem [256];
  int          n_asserts = 0;
  int          n_fails   = 0;
  logic [7:0]  hp;

  always #5 clk = ~clk;

  assign opcode = mem[pc];

  pic_sequencer #(.PC_W(8), .OPCODE_W(14)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .opcode    (opcode),
    .skip      (skip),
    .clk1      (clk1),
    .clk2      (clk2),
    .clk3      (clk3),
    .clk4      (clk4),
    .pc        (pc),
    .inst_reg  (inst_reg),
    .flush     (flush),
    .ram_rd    (ram_rd),
    .ram_wr    (ram_wr),
    .w_wr      (w_wr),
    .stack_err (stack_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full instruction cycle: enters Q1 and stops just after entering Q4.
  task automatic instr(input string tag, input logic [7:0] epc, input logic [13:0] eir,
                       input logic efl, input logic erd, input logic ewr, input logic eww,
                       input logic sk);
    tick();
    chk({tag, "/q1_phase"}, {clk1, clk2, clk3, clk4}, 4'b1000);
    chk({tag, "/pc"}, pc, epc);
    chk({tag, "/ir"}, inst_reg, eir);
    chk({tag, "/flush"}, flush, efl);
    chk({tag, "/q1_strb"}, {ram_rd, ram_wr, w_wr}, 3'b000);
    tick();
    chk({tag, "/q2_phase"}, {clk1, clk2, clk3, clk4}, 4'b0100);
    chk({tag, "/q2_strb"}, {ram_rd, ram_wr, w_wr}, {erd, 2'b00});
    tick();
    chk({tag, "/q3_phase"}, {clk1, clk2, clk3, clk4}, 4'b0010);
    chk({tag, "/q3_strb"}, {ram_rd, ram_wr, w_wr}, 3'b000);
    skip = sk;
    tick();
    chk({tag, "/q4_phase"}, {clk1, clk2, clk3, clk4}, 4'b0001);
    chk({tag, "/q4_strb"}, {ram_rd, ram_wr, w_wr}, {1'b0, ewr, eww});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 14'h0000;
    mem[8'h00] = 14'h0787;  // ADDWF 0x07,1
    mem[8'h01] = 14'h3025;  // MOVLW 0x25
    mem[8'h02] = 14'h1805;  // BTFSC, skipped over 0x03
    mem[8'h03] = 14'h3011;
    mem[8'h04] = 14'h1805;  // BTFSC, not taken
    mem[8'h05] = 14'h2820;  // GOTO 0x20
    mem[8'h20] = 14'h2040;  // CALL 0x40
    mem[8'h21] = 14'h2850;  // GOTO 0x50
    mem[8'h40] = 14'h0008;  // RETURN
    mem[8'h42] = 14'h3455;  // RETLW 0x55
    mem[8'h44] = 14'h3077;  // MOVLW 0x77
    for (int k = 0; k < 9; k++) mem[8'h50 + k] = 14'h2051 + 14'(k);
    mem[8'h5a] = 14'h3077;

    reset = 1'b0;
    run   = 1'b1;
    skip  = 1'b0;
    tick();
    tick();
    chk("rst/phase", {clk1, clk2, clk3, clk4}, 4'b0000);
    chk("rst/pc", pc, 8'h00);
    chk("rst/ir", inst_reg, 14'h0000);
    chk("rst/flush", flush, 1'b1);
    chk("rst/strb", {ram_rd, ram_wr, w_wr}, 3'b000);
    chk("rst/err", stack_err, 1'b0);

    reset = 1'b1;
    #1;
    chk("rel/phase", {clk1, clk2, clk3, clk4}, 4'b0000);

    instr("boot",   8'h00, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    instr("addwf",  8'h01, 14'h0787, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    instr("movlw",  8'h02, 14'h3025, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    instr("btfsc1", 8'h03, 14'h1805, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    instr("skipfl", 8'h04, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    instr("btfsc0", 8'h05, 14'h1805, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    instr("goto",   8'h06, 14'h2820, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    instr("gotofl", 8'h20, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    instr("call",   8'h21, 14'h2040, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    instr("callfl", 8'h40, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    instr("return", 8'h41, 14'h0008, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef PIC_SEQ_STACK_EN
    instr("retfl",  8'h21, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ret/err", stack_err, 1'b0);
    instr("goto50", 8'h22, 14'h2850, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    instr("g50fl",  8'h50, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      instr("ncall",   8'h51 + 8'(k), 14'h2051 + 14'(k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      instr("ncallfl", 8'h51 + 8'(k), 14'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ncall/err", stack_err, (k == 8) ? 1'b1 : 1'b0);
    end
    hp = 8'h5a;
`else
    instr("retseq", 8'h42, 14'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ret/err", stack_err, 1'b0);
    instr("retlw",  8'h43, 14'h3455, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    hp = 8'h44;
`endif

    // Halt request during Q2: the cycle finishes, then PC/IR freeze
    tick();
    chk("halt/q1_pc", pc, hp);
    chk("halt/q1_ir", inst_reg, 14'h0000);
    tick();
    run = 1'b0;
    tick();
    chk("halt/q3_phase", {clk1, clk2, clk3, clk4}, 4'b0010);
    tick();
    chk("halt/q4_phase", {clk1, clk2, clk3, clk4}, 4'b0001);
    tick();
    chk("halt/phase", {clk1, clk2, clk3, clk4}, 4'b0000);
    chk("halt/pc", pc, hp + 8'h01);
    chk("halt/ir", inst_reg, 14'h3077);
    repeat (3) tick();
    chk("halt/hold_phase", {clk1, clk2, clk3, clk4}, 4'b0000);
    chk("halt/hold_pc", pc, hp + 8'h01);
    run = 1'b1;
    tick();
    chk("resume/phase", {clk1, clk2, clk3, clk4}, 4'b1000);
    chk("resume/pc", pc, hp + 8'h01);
    chk("resume/ir", inst_reg, 14'h3077);
    tick();
    tick();
    tick();
    chk("resume/q4_wwr", {clk4, w_wr}, 2'b11);

    // Asynchronous reset in the middle of Q4
    reset = 1'b0;
    #1;
    chk("arst/phase", {clk1, clk2, clk3, clk4}, 4'b0000);
    chk("arst/strb", {ram_rd, ram_wr, w_wr}, 3'b000);
    chk("arst/pc", pc, 8'h00);
    chk("arst/ir", inst_reg, 14'h0000);
    chk("arst/flush", flush, 1'b1);
    chk("arst/err", stack_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
